// File: rtl/ofdm_subcarrier_extract.sv
// Extracts the 48 data subcarriers from 64-bin equalized OFDM symbols, dropping guard, DC and pilot bins.
// Define OFDM_SUBCARRIER_EXTRACT_PILOT_OUT_EN to route pilot bins to a separate p_* output stream.
module ofdm_subcarrier_extract #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 sof_i,
  input  logic [WIDTH-1:0]     i_tdata,
  input  logic                 i_tlast,
  input  logic                 i_tvalid,
  output logic                 i_tready,
  output logic [WIDTH-1:0]     o_tdata,
  output logic                 o_tlast,
  output logic                 o_tvalid,
  input  logic                 o_tready,
`ifdef OFDM_SUBCARRIER_EXTRACT_PILOT_OUT_EN
  output logic [WIDTH-1:0]     p_tdata,
  output logic                 p_tlast,
  output logic                 p_tvalid,
  input  logic                 p_tready,
`endif
  output logic [CNT_WIDTH-1:0] sym_count,
  output logic                 err_short,
  output logic                 err_long
);

  logic                 sof_q;
  logic [5:0]           bin_q, bin_d;
  logic [CNT_WIDTH-1:0] sym_q, sym_d;
  logic [WIDTH-1:0]     o_data_q, o_data_d;
  logic                 o_last_q, o_last_d;
  logic                 o_valid_q, o_valid_d;
  logic                 err_short_q, err_short_d;
  logic                 err_long_q, err_long_d;
  logic                 sof, is_pilot, is_kept, ready, hs, last_bin, sym_end;
`ifdef OFDM_SUBCARRIER_EXTRACT_PILOT_OUT_EN
  logic [WIDTH-1:0]     p_data_q, p_data_d;
  logic                 p_last_q, p_last_d;
  logic                 p_valid_q, p_valid_d;
`endif

  always_comb begin
    sof      = sof_i & ~sof_q;
    is_pilot = (bin_q == 6'd11) || (bin_q == 6'd25) || (bin_q == 6'd39) || (bin_q == 6'd53);
    is_kept  = (bin_q >= 6'd6) && (bin_q <= 6'd58) && !is_pilot && (bin_q != 6'd32);

    // Dropped bins never stall; kept bins only wait on a full output register.
    ready = 1'b1;
    if (is_kept) ready = o_tready | ~o_valid_q;
`ifdef OFDM_SUBCARRIER_EXTRACT_PILOT_OUT_EN
    if (is_pilot) ready = p_tready | ~p_valid_q;
`endif
    hs       = i_tvalid & ready;
    last_bin = (bin_q == 6'd63);
    sym_end  = hs & (i_tlast | last_bin);

    bin_d = bin_q;
    if (sof)     bin_d = 6'd0;
    else if (hs) bin_d = sym_end ? 6'd0 : bin_q + 6'd1;

    sym_d = sym_q;
    if (sof) sym_d = '0;
    else if (sym_end && (sym_q != {CNT_WIDTH{1'b1}}))
      sym_d = sym_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    err_short_d = ~sof & hs & i_tlast & ~last_bin;
    err_long_d  = ~sof & hs & last_bin & ~i_tlast;

    o_valid_d = o_valid_q;
    o_data_d  = o_data_q;
    o_last_d  = o_last_q;
    if (sof) begin
      o_valid_d = 1'b0;
    end else if (hs && is_kept) begin
      o_valid_d = 1'b1;
      o_data_d  = i_tdata;
      o_last_d  = (bin_q == 6'd58);
    end else if (o_tready) begin
      o_valid_d = 1'b0;
    end

`ifdef OFDM_SUBCARRIER_EXTRACT_PILOT_OUT_EN
    p_valid_d = p_valid_q;
    p_data_d  = p_data_q;
    p_last_d  = p_last_q;
    if (sof) begin
      p_valid_d = 1'b0;
    end else if (hs && is_pilot) begin
      p_valid_d = 1'b1;
      p_data_d  = i_tdata;
      p_last_d  = (bin_q == 6'd53);
    end else if (p_tready) begin
      p_valid_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sof_q       <= 1'b0;
      bin_q       <= '0;
      sym_q       <= '0;
      o_data_q    <= '0;
      o_last_q    <= 1'b0;
      o_valid_q   <= 1'b0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
    end else begin
      sof_q       <= sof_i;
      bin_q       <= bin_d;
      sym_q       <= sym_d;
      o_data_q    <= o_data_d;
      o_last_q    <= o_last_d;
      o_valid_q   <= o_valid_d;
      err_short_q <= err_short_d;
      err_long_q  <= err_long_d;
    end
  end

`ifdef OFDM_SUBCARRIER_EXTRACT_PILOT_OUT_EN
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      p_data_q  <= '0;
      p_last_q  <= 1'b0;
      p_valid_q <= 1'b0;
    end else begin
      p_data_q  <= p_data_d;
      p_last_q  <= p_last_d;
      p_valid_q <= p_valid_d;
    end
  end

  assign p_tdata  = p_data_q;
  assign p_tlast  = p_last_q;
  assign p_tvalid = p_valid_q;
`endif

  assign i_tready  = ready;
  assign o_tdata   = o_data_q;
  assign o_tlast   = o_last_q;
  assign o_tvalid  = o_valid_q;
  assign sym_count = sym_q;
  assign err_short = err_short_q;
  assign err_long  = err_long_q;

endmodule

// File: tb/tb_ofdm_subcarrier_extract.sv
// Directed bench for ofdm_subcarrier_extract: ramp, backpressure, short/long symbols, sof restart, async reset.
// Pilot-stream checks are compiled in when OFDM_SUBCARRIER_EXTRACT_PILOT_OUT_EN is defined.
`timescale 1ns/1ps
module tb_ofdm_subcarrier_extract;
  localparam int WIDTH     = 32;
  localparam int CNT_WIDTH = 16;

  logic                 clk_i = 1'b0;
  logic                 rst_n_i = 1'b0;
  logic                 sof_i = 1'b0;
  logic [WIDTH-1:0]     i_tdata = '0;
  logic                 i_tlast = 1'b0;
  logic                 i_tvalid = 1'b0;
  logic                 i_tready;
  logic [WIDTH-1:0]     o_tdata;
  logic                 o_tlast;
  logic                 o_tvalid;
  logic                 o_tready;
  logic [CNT_WIDTH-1:0] sym_count;
  logic                 err_short;
  logic                 err_long;
`ifdef OFDM_SUBCARRIER_EXTRACT_PILOT_OUT_EN
  logic [WIDTH-1:0]     p_tdata;
  logic                 p_tlast;
  logic                 p_tvalid;
  logic                 p_tready = 1'b1;
`endif

  logic ot_fixed = 1'b1;
  logic bp_en    = 1'b0;
  logic bp_tog   = 1'b0;
  assign o_tready = bp_en ? bp_tog : ot_fixed;

  int n_tests = 0;
  int n_fail  = 0;
  int n_err_short = 0;
  int n_err_long  = 0;
  int n_hold_bad  = 0;
  logic             prev_stall = 1'b0;
  logic [WIDTH:0]   prev_word  = '0;
  logic [WIDTH:0]   obs_q[$];
  logic [WIDTH:0]   exp_q[$];
  int               obs_rd = 0;
  logic [WIDTH:0]   p_obs_q[$];
  logic [WIDTH:0]   p_exp_q[$];
  int               p_obs_rd = 0;

  ofdm_subcarrier_extract #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .sof_i     (sof_i),
    .i_tdata   (i_tdata),
    .i_tlast   (i_tlast),
    .i_tvalid  (i_tvalid),
    .i_tready  (i_tready),
    .o_tdata   (o_tdata),
    .o_tlast   (o_tlast),
    .o_tvalid  (o_tvalid),
    .o_tready  (o_tready),
`ifdef OFDM_SUBCARRIER_EXTRACT_PILOT_OUT_EN
    .p_tdata   (p_tdata),
    .p_tlast   (p_tlast),
    .p_tvalid  (p_tvalid),
    .p_tready  (p_tready),
`endif
    .sym_count (sym_count),
    .err_short (err_short),
    .err_long  (err_long)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    #1;
    bp_tog = ~bp_tog;
  end

  // Output monitor sampled on the falling edge, between DUT updates.
  always @(negedge clk_i) begin
    if (rst_n_i) begin
      if (prev_stall && o_tvalid && ({o_tlast, o_tdata} !== prev_word)) n_hold_bad++;
      if (o_tvalid && o_tready) obs_q.push_back({o_tlast, o_tdata});
`ifdef OFDM_SUBCARRIER_EXTRACT_PILOT_OUT_EN
      if (p_tvalid && p_tready) p_obs_q.push_back({p_tlast, p_tdata});
`endif
      if (err_short) n_err_short++;
      if (err_long)  n_err_long++;
      prev_stall = o_tvalid && !o_tready;
      prev_word  = {o_tlast, o_tdata};
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit kept_ref(input int b);
    return (b >= 6) && (b <= 58) && (b != 11) && (b != 25) && (b != 32) && (b != 39) && (b != 53);
  endfunction

  function automatic bit pilot_ref(input int b);
    return (b == 11) || (b == 25) || (b == 39) || (b == 53);
  endfunction

  task automatic send_beat(input logic [WIDTH-1:0] d, input logic last, output int waits);
    logic rdy;
    i_tvalid = 1'b1;
    i_tdata  = d;
    i_tlast  = last;
    waits    = 0;
    rdy      = 1'b0;
    while (!rdy && waits < 200) begin
      @(negedge clk_i);
      rdy = i_tready;
      @(posedge clk_i);
      #1;
      waits++;
    end
    if (!rdy) check("beat_timeout", 0, 1);
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
  endtask

  task automatic send_sym(input int base, input int nbins, input bit last_at_end,
                          input bit record, input bit chk_drop);
    int w;
    int bin;
    for (int b = 0; b < nbins; b++) begin
      bin = b % 64;
      send_beat(WIDTH'(base + b), last_at_end && (b == nbins - 1), w);
      if (record && kept_ref(bin)) exp_q.push_back({(bin == 58), WIDTH'(base + b)});
      if (record && pilot_ref(bin)) p_exp_q.push_back({(bin == 53), WIDTH'(base + b)});
      if (chk_drop && !kept_ref(bin) && !pilot_ref(bin)) check("drop_nostall", w, 1);
    end
  endtask

  task automatic sof_pulse();
    sof_i    = 1'b1;
    i_tvalid = 1'b0;
    @(posedge clk_i);
    #1;
    sof_i = 1'b0;
  endtask

  task automatic drain();
    repeat (4) @(posedge clk_i);
    #1;
  endtask

  task automatic compare_stream(input string tag);
    int n_obs;
    n_obs = obs_q.size() - obs_rd;
    check({tag, "_count"}, n_obs, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < n_obs; i++) check(tag, obs_q[obs_rd + i], exp_q[i]);
    obs_rd = obs_q.size();
    exp_q.delete();
`ifdef OFDM_SUBCARRIER_EXTRACT_PILOT_OUT_EN
    n_obs = p_obs_q.size() - p_obs_rd;
    check({tag, "_pilot_count"}, n_obs, p_exp_q.size());
    for (int i = 0; i < p_exp_q.size() && i < n_obs; i++)
      check({tag, "_pilot"}, p_obs_q[p_obs_rd + i], p_exp_q[i]);
`endif
    p_obs_rd = p_obs_q.size();
    p_exp_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int es0, el0, hb0;

    repeat (3) @(posedge clk_i);
    #2;
    check("rst_o_tvalid", o_tvalid, 0);
    check("rst_o_tdata", o_tdata, 0);
    check("rst_o_tlast", o_tlast, 0);
    check("rst_sym_count", sym_count, 0);
    check("rst_err_short", err_short, 0);
    check("rst_err_long", err_long, 0);
    check("rst_i_tready", i_tready, 1);
    rst_n_i = 1'b1;
    @(posedge clk_i);
    #1;

    // Ramp symbol with full throughput.
    es0 = n_err_short; el0 = n_err_long;
    send_sym(0, 64, 1'b1, 1'b1, 1'b0);
    drain();
    compare_stream("ramp");
    check("ramp_sym_count", sym_count, 1);
    check("ramp_err_short", n_err_short - es0, 0);
    check("ramp_err_long", n_err_long - el0, 0);

    // Four symbols with o_tready toggling every cycle.
    sof_pulse();
    es0 = n_err_short; el0 = n_err_long; hb0 = n_hold_bad;
    bp_en = 1'b1;
    for (int s = 0; s < 4; s++) send_sym(1000 + s * 64, 64, 1'b1, 1'b1, 1'b1);
    bp_en = 1'b0;
    drain();
    compare_stream("bp");
    check("bp_sym_count", sym_count, 4);
    check("bp_hold_stable", n_hold_bad - hb0, 0);
    check("bp_err_short", n_err_short - es0, 0);
    check("bp_err_long", n_err_long - el0, 0);

    // Truncated symbol (i_tlast at bin 40), then a normal symbol.
    sof_pulse();
    es0 = n_err_short; el0 = n_err_long;
    send_sym(0, 41, 1'b1, 1'b1, 1'b0);
    send_sym(100, 64, 1'b1, 1'b1, 1'b0);
    drain();
    compare_stream("short");
    check("short_err_short", n_err_short - es0, 1);
    check("short_err_long", n_err_long - el0, 0);
    check("short_sym_count", sym_count, 2);

    // 128 beats with no i_tlast.
    sof_pulse();
    es0 = n_err_short; el0 = n_err_long;
    send_sym(0, 128, 1'b0, 1'b1, 1'b0);
    drain();
    compare_stream("long");
    check("long_err_long", n_err_long - el0, 2);
    check("long_err_short", n_err_short - es0, 0);
    check("long_sym_count", sym_count, 2);

    // sof mid-symbol flushes a stalled output and restarts the bin count.
    send_sym(500, 20, 1'b0, 1'b0, 1'b0);
    ot_fixed = 1'b0;
    @(posedge clk_i);
    #1;
    check("sof_pending_valid", o_tvalid, 1);
    obs_rd   = obs_q.size();
    p_obs_rd = p_obs_q.size();
    sof_pulse();
    check("sof_flush_valid", o_tvalid, 0);
    check("sof_sym_clear", sym_count, 0);
    ot_fixed = 1'b1;
    send_sym(600, 3, 1'b0, 1'b0, 1'b0);
    sof_i = 1'b1;
    send_beat(32'h0000_DEAD, 1'b0, w);
    sof_i = 1'b0;
    send_sym(200, 64, 1'b1, 1'b1, 1'b0);
    drain();
    compare_stream("sof");
    check("sof_sym_count", sym_count, 1);

    // Asynchronous reset with an output pending.
    ot_fixed = 1'b0;
    send_sym(700, 7, 1'b0, 1'b0, 1'b0);
    check("arst_pre_valid", o_tvalid, 1);
    #3;
    rst_n_i = 1'b0;
    #1;
    check("arst_o_tvalid", o_tvalid, 0);
    check("arst_o_tdata", o_tdata, 0);
    check("arst_sym_count", sym_count, 0);
    #3;
    rst_n_i = 1'b1;
    @(posedge clk_i);
    #1;
    ot_fixed = 1'b1;
    obs_rd   = obs_q.size();
    p_obs_rd = p_obs_q.size();
    send_sym(300, 64, 1'b1, 1'b1, 1'b0);
    drain();
    compare_stream("post_rst");
    check("post_rst_sym_count", sym_count, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
